// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Row vectors are zero-extended to MAX_ROWS bits before they reach onehot_idx().
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scan_state_t;

  localparam int MAX_ROWS  = 32;
  localparam int ROW_IDX_W = 5;

  typedef struct packed {
    logic [ROW_IDX_W-1:0] idx;
    logic                 onehot;
  } onehot_t;

  // onehot is set only when exactly one bit is high; idx then names that bit.
  function automatic onehot_t onehot_idx(input logic [MAX_ROWS-1:0] vec);
    onehot_t res;
    res.idx    = '0;
    res.onehot = (vec != '0) && ((vec & (vec - MAX_ROWS'(1))) == '0);
    for (int i = 0; i < MAX_ROWS; i++) begin
      if (vec[i]) begin
        res.idx = ROW_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
// The head entry is always visible on pop_data; push while full is accepted only alongside a pop.
module keypad_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// ROWSxCOLS matrix keypad scanner: prescaled column scan, row synchroniser,
// tick-based press/release debounce with ghost rejection, and a buffered key-event output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int SCAN_DIV   = 100000,
  parameter  int DEBOUNCE   = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int KEY_W      = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             overflow,
  output logic             scan_tick
);

  localparam int COL_W   = $clog2(COLS);
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);
  localparam int PRESC_W = $clog2(SCAN_DIV);

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [ROWS-1:0]      sync1_q, sync1_d;
  logic [ROWS-1:0]      sync2_q, sync2_d;
  scan_state_t          state_q, state_d;
  logic [COL_W-1:0]     col_idx_q, col_idx_d;
  logic [COLS-1:0]      col_oh_q, col_oh_d;
  logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 key_down_q, key_down_d;
  logic                 overflow_q, overflow_d;

  logic                 tick;
  logic [MAX_ROWS-1:0]  rs_ext;
  onehot_t              det;
  logic [ROWS-1:0]      row_oh_latched;
  logic                 advance;
  logic                 push;
  logic [ROW_IDX_W-1:0] push_row;
  logic [KEY_W-1:0]     push_code;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign tick      = (presc_q == PRESC_W'(SCAN_DIV - 1));
  assign scan_tick = tick;
  assign col       = ~col_oh_q;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;
  assign key_valid = !fifo_empty;
  assign pop       = key_valid && key_ready;

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    sync1_d = ~row;
    sync2_d = sync1_q;
  end

  always_comb begin
    rs_ext              = '0;
    rs_ext[ROWS-1:0]    = sync2_q;
  end

  assign det            = onehot_idx(rs_ext);
  assign row_oh_latched = ROWS'(1) << row_idx_q;

  // Column stays put while a key is being qualified or held, so the same intersection is resampled.
  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    key_down_d = key_down_q;
    push       = 1'b0;
    push_row   = row_idx_q;
    advance    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (sync2_q == '0) begin
            advance = 1'b1;
          end else if (det.onehot) begin
            row_idx_d = det.idx;
            push_row  = det.idx;
            if (DEBOUNCE == 1) begin
              push       = 1'b1;
              key_down_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_HELD;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (sync2_q == row_oh_latched) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              push       = 1'b1;
              key_down_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_HELD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (sync2_q == '0) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              key_down_d = 1'b0;
              cnt_d      = '0;
              advance    = 1'b1;
              state_d    = ST_SCAN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_comb begin
    col_idx_d = col_idx_q;
    col_oh_d  = col_oh_q;
    if (advance) begin
      col_idx_d = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
      col_oh_d  = {col_oh_q[COLS-2:0], col_oh_q[COLS-1]};
    end
  end

  assign push_code  = KEY_W'(32'(push_row) * 32'(COLS) + 32'(col_idx_q));
  // A pop in the same cycle frees a slot, so only an unmatched push into a full FIFO is lost.
  assign overflow_d = push && fifo_full && !pop;

  keypad_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .pop_data  (key_code),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= ST_SCAN;
      col_idx_q  <= '0;
      col_oh_q   <= COLS'(1);
      row_idx_q  <= '0;
      cnt_q      <= '0;
      key_down_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      col_oh_q   <= col_oh_d;
      row_idx_q  <= row_idx_d;
      cnt_q      <= cnt_d;
      key_down_q <= key_down_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
